param_reg_array: RTL
====================

Name: param_reg_array

Overview:
Parametrised successor of the mips789 register file. Width, address depth and read-port count are set by parameters. Writes carry per-byte enables. R0 hardwiring is optional. Sits in the decode stage of the pipeline. Keeps the existing pause / rd_clk_cls staging semantics and write-to-read forwarding. Adds an asynchronous clear of all state.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8.
AW, 5, address width; DEPTH = 2**AW entries.
NRD, 2, number of read ports (1..4).
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register.

Ports:
clock  in  1  sole clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
pause  in  1  pipeline stall; freezes the write and read staging registers.
rd_clk_cls  in  1  holds the read-address staging registers only.
wren  in  1  write request.
wraddress  in  AW  write address.
data  in  WIDTH  write data.
be  in  WIDTH/8  byte enables; bit k covers data[8k+7:8k].
rdaddress  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
q  out  NRD*WIDTH  read data; port i uses bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset (rst_n=0, asynchronous):
  - r_data, r_wraddress, r_be, r_wren and every r_rdaddress[i] clear to 0.
  - All DEPTH bank entries clear to 0.
  - All q read 0 while reset is asserted and after release until the first write commits.
  - Reset mid-operation discards a staged, uncommitted write.
- Write staging: at the edge, if pause=0, capture data, wraddress, be and wren into r_*. If pause=1, hold them.
- Read staging: at the edge, if pause=0 and rd_clk_cls=0, capture every rdaddress[i]. Otherwise hold.
- Commit:
  - At the edge, if r_wren=1, bank[r_wraddress] byte k <= r_data byte k for each r_be[k]=1. Bytes with r_be[k]=0 are unchanged.
  - Commit is independent of pause, so a staged write commits once even while paused. Re-commit of identical data while paused is harmless and allowed.
  - With ZERO_REG=1 and r_wraddress=0, no commit.
  - be=0 with wren=1 is legal and changes nothing.
- Read (combinational from staged state), per port i with address A = r_rdaddress[i]:
  - ZERO_REG=1 and A=0: q_i = 0.
  - Else if r_wren=1 and r_wraddress=A: q_i byte k = r_be[k] ? r_data byte k : bank[A] byte k (byte-merge forwarding).
  - Else: q_i = bank[A].
- Latency: a write presented before edge N is visible on a port whose address is staged at edge N, immediately after edge N via forwarding. From after edge N+1 it is read from the bank. Read latency is one edge from rdaddress to q.
- Multiple ports on the same address return identical values. Ports are fully independent. There is no port-count arbitration.
- Write and read staged to the same address on the same edge: the read returns the new (merged) value.
- Consecutive writes to the same address on back-to-back edges: the second write merges over the first, which has been committed by then.
- Address wrap does not occur: all AW-bit values are valid entries.

Test Plan:
1. rst_n=0 for 2 cycles, then release with wren=0 and rdaddress ports 0/1 = 1/31 -> q0=q1=0x00000000. Assert rst_n=0 asynchronously mid-cycle after staging a write of R5=0x11111111 -> no commit; R5 later reads 0.
2. Write R3=0xDEADBEEF, be=4'b1111, with port0 rdaddress=3 in the same cycle -> q0=0xDEADBEEF after that edge (forwarded) and still after the next edge (bank).
3. Write 0x00000011 be=4'b0001 to R3 (holding 0xDEADBEEF), port1 rdaddress=3 -> q1=0xDEADBE11 both on the forward cycle and thereafter. be=4'b0000 write -> value unchanged.
4. ZERO_REG=1: write R0=0x12345678 -> q reads 0 on all ports. Rebuild with ZERO_REG=0 -> reads 0x12345678.
5. Stage R7=0xA5A5A5A5, then pause=1 for 3 cycles while toggling data, wraddress and rdaddress -> q unchanged throughout; R7 committed; no other entry written. With pause=0 and rd_clk_cls=1, writes proceed and read addresses hold.
6. NRD=3, AW=4, WIDTH=64: write R15=0x0123456789ABCDEF, all three ports address 15 -> three identical outputs. Writes to R14 and R15 on back-to-back edges -> both correct.

Source files
------------

// File: rtl/param_reg_array.sv
`default_nettype none
// ============================================================================
// Module   : param_reg_array
// Purpose  : Parametrised decode-stage register file. Writes carry per-byte
//            enables and are staged one edge before they commit to the bank.
//            Read addresses are also staged, and reads are combinational from
//            the staged state. A write that is staged at the same time as a
//            matching read address is byte-merge forwarded to that read port.
//            Entry 0 can be hardwired to zero. The asynchronous reset clears
//            all state, including the bank.
// Revision : 1.0 - initial parametrised release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     data width in bits (multiple of 8)
//   AW        address width, 2**AW entries
//   NRD       number of read ports (1..4)
//   ZERO_REG  1: entry 0 reads as zero and ignores writes
// Ports
//   clock       in   1          rising-edge clock
//   rst_n       in   1          asynchronous active-low reset
//   pause       in   1          stall: holds write and read staging
//   rd_clk_cls  in   1          holds read-address staging only
//   wren        in   1          write request
//   wraddress   in   AW         write address
//   data        in   WIDTH      write data
//   be          in   WIDTH/8    byte enables, bit k -> data[8k+7:8k]
//   rdaddress   in   NRD*AW     read addresses, port i at [i*AW +: AW]
//   q           out  NRD*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
// ============================================================================
module param_reg_array #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 pause,
  input  logic                 rd_clk_cls,
  input  logic                 wren,
  input  logic [AW-1:0]        wraddress,
  input  logic [WIDTH-1:0]     data,
  input  logic [WIDTH/8-1:0]   be,
  input  logic [NRD*AW-1:0]    rdaddress,
  output logic [NRD*WIDTH-1:0] q
);

  localparam int unsigned c_nbytes = WIDTH / 8;
  localparam int unsigned c_depth  = 2 ** AW;

  // Staged write request
  logic [WIDTH-1:0]    r_data;
  logic [AW-1:0]       r_wraddress;
  logic [c_nbytes-1:0] r_be;
  logic                r_wren;

  // Staged read addresses, one per port
  logic [AW-1:0]       r_rdaddress [NRD];

  // Storage
  logic [WIDTH-1:0]    r_bank [c_depth];

  // A staged write to entry 0 is dropped when entry 0 is hardwired.
  logic                w_commit;
  assign w_commit = r_wren && !(ZERO_REG && (r_wraddress == '0));

  // --------------------------------------------------------------------------
  // Write staging: frozen by pause.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_wraddress <= '0;
      r_be        <= '0;
      r_wren      <= 1'b0;
    end else if (!pause) begin
      r_data      <= data;
      r_wraddress <= wraddress;
      r_be        <= be;
      r_wren      <= wren;
    end
  end

  // --------------------------------------------------------------------------
  // Read-address staging: frozen by either pause or rd_clk_cls.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NRD; i++) begin
        r_rdaddress[i] <= '0;
      end
    end else if (!pause && !rd_clk_cls) begin
      for (int i = 0; i < NRD; i++) begin
        r_rdaddress[i] <= rdaddress[i*AW +: AW];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Commit. Deliberately not gated by pause: a write staged before a stall
  // still lands. While the stall lasts, the same write is re-applied on every
  // edge with identical data, which leaves the bank unchanged.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < c_depth; e++) begin
        r_bank[e] <= '0;
      end
    end else if (w_commit) begin
      for (int k = 0; k < c_nbytes; k++) begin
        if (r_be[k]) begin
          r_bank[r_wraddress][8*k +: 8] <= r_data[8*k +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. The bank word is overlaid with the enabled bytes of a staged
  // write to the same address. This makes a write visible on the edge where
  // it is staged, one edge before it reaches the bank.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NRD; i++) begin : g_rd_port
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_bank_word;
    logic             w_hit;
    logic [WIDTH-1:0] w_q;

    assign w_addr      = r_rdaddress[i];
    assign w_bank_word = r_bank[w_addr];
    assign w_hit       = r_wren && (r_wraddress == w_addr);

    always_comb begin
      w_q = w_bank_word;
      if (w_hit) begin
        for (int k = 0; k < c_nbytes; k++) begin
          if (r_be[k]) begin
            w_q[8*k +: 8] = r_data[8*k +: 8];
          end
        end
      end
      // The forward path could otherwise expose a write aimed at entry 0.
      if (ZERO_REG && (w_addr == '0)) begin
        w_q = '0;
      end
    end

    assign q[i*WIDTH +: WIDTH] = w_q;
  end

endmodule
`default_nettype wire
